// File: rtl/cacheline_adapter.sv
// cacheline_adapter: bridges the cache's 256-bit line port (dfp_*) to a
// 64-bit burst memory (bmem_*). Each line read or write becomes one 4-beat
// burst. The cache gets a single-cycle dfp_resp when the transfer completes.
// Optional build macro: CACHELINE_ADAPTER_RADDR_CHECK_EN. When it is defined,
// read beats whose bmem_raddr does not match the burst address are dropped.
module cacheline_adapter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_BURST, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [LINE_W-1:0] wline;
  logic [ADDR_W-1:0] addr_aligned;
  logic              beat_ok;
  logic              unused_offset;

  assign cnt_nxt       = cnt + CNT_W'(1);
  assign addr_aligned  = {dfp_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign unused_offset = ^dfp_addr[OFF_W-1:0];

  // bmem_addr doubles as the latched burst address for the whole transaction.
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
  assign beat_ok = bmem_rvalid && (bmem_raddr == bmem_addr);

  // Flag read beats tagged with some other burst's address.
  always_ff @(posedge clk) begin
    if (!rst && state == RD_WAIT && bmem_rvalid && bmem_raddr != bmem_addr)
      $error("cacheline_adapter: beat raddr %h does not match %h", bmem_raddr, bmem_addr);
  end
`else
  logic unused_raddr;
  assign beat_ok      = bmem_rvalid;
  assign unused_raddr = ^bmem_raddr;
`endif

  // Simultaneous read and write requests are illegal; the write is served.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE)
      assert (!(dfp_read && dfp_write))
        else $error("cacheline_adapter: dfp_read and dfp_write both asserted");
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wline      <= '0;
      dfp_rdata  <= '0;
      dfp_resp   <= 1'b0;
      bmem_addr  <= '0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dfp_write && bmem_ready) begin
            bmem_addr  <= addr_aligned;
            wline      <= dfp_wdata;
            bmem_wdata <= dfp_wdata[BEAT_W-1:0];
            bmem_write <= 1'b1;
            cnt        <= '0;
            state      <= WR_BURST;
          end else if (dfp_read && bmem_ready) begin
            bmem_addr <= addr_aligned;
            bmem_read <= 1'b1;
            cnt       <= '0;
            state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          bmem_read <= 1'b0;
          if (beat_ok) begin
            dfp_rdata[BEAT_W*cnt +: BEAT_W] <= bmem_rdata;
            cnt <= cnt_nxt;
            if (cnt == LAST) begin
              dfp_resp <= 1'b1;
              state    <= RESP;
            end
          end
        end
        WR_BURST: begin
          if (cnt == LAST) begin
            bmem_write <= 1'b0;
            cnt        <= '0;
            dfp_resp   <= 1'b1;
            state      <= RESP;
          end else begin
            cnt        <= cnt_nxt;
            bmem_wdata <= wline[BEAT_W*cnt_nxt +: BEAT_W];
          end
        end
        RESP: begin
          dfp_resp <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter: scoreboard bench for cacheline_adapter. Expected
// bursts and responses are queued as stimulus is driven and popped by a
// monitor when the DUT presents them.
module tb_cacheline_adapter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] dfp_addr;
  logic              dfp_read;
  logic              dfp_write;
  logic [LINE_W-1:0] dfp_wdata;
  logic [LINE_W-1:0] dfp_rdata;
  logic              dfp_resp;
  logic [ADDR_W-1:0] bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [ADDR_W-1:0] bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  always #5 clk = ~clk;

  cacheline_adapter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  int errors = 0;
  int checks = 0;

  logic [ADDR_W-1:0]        rd_q[$];    // expected bmem_read addresses
  logic [ADDR_W+BEAT_W-1:0] wr_q[$];    // expected {bmem_addr, bmem_wdata} beats
  logic [LINE_W-1:0]        resp_q[$];  // expected dfp_rdata at each dfp_resp
  logic [LINE_W-1:0]        line_model = '0;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // Monitor: every DUT-produced event must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bmem_read) begin
        if (rd_q.size() == 0) chk("unexpected_read", LINE_W'(bmem_read), '0);
        else chk("read_addr", LINE_W'(bmem_addr), LINE_W'(rd_q.pop_front()));
      end
      if (bmem_write) begin
        if (wr_q.size() == 0) chk("unexpected_write", LINE_W'(bmem_write), '0);
        else chk("write_beat", LINE_W'({bmem_addr, bmem_wdata}), LINE_W'(wr_q.pop_front()));
      end
      if (dfp_resp) begin
        if (resp_q.size() == 0) chk("unexpected_resp", LINE_W'(dfp_resp), '0);
        else chk("resp_rdata", dfp_rdata, resp_q.pop_front());
      end
    end
  end

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] line,
                         input int gap, input int stall);
    logic [ADDR_W-1:0] al;
    int n;
    al = {addr[ADDR_W-1:5], 5'b0};
    rd_q.push_back(al);
    resp_q.push_back(line);
    line_model = line;
    dfp_addr   = addr;
    dfp_read   = 1'b1;
    bmem_ready = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      tick;
      chk("bp_no_read", LINE_W'(bmem_read), '0);
    end
    bmem_ready = 1'b1;
    n = 0;
    do begin tick; n++; end while (!bmem_read && n < 20);
    chk("read_issue_lat", LINE_W'(n), LINE_W'(1));
    for (int i = 0; i < 4; i++) begin
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
      if (i == 2) begin
        bmem_raddr  = al ^ 32'h0000_0100;
        bmem_rdata  = '1;
        bmem_rvalid = 1'b1;
        tick;
      end
`endif
      bmem_raddr  = al;
      bmem_rdata  = line[BEAT_W*i +: BEAT_W];
      bmem_rvalid = 1'b1;
      tick;
      if (i == 0) chk("read_pulse_once", LINE_W'(bmem_read), '0);
      bmem_rvalid = 1'b0;
      if (i < 3) for (int g = 0; g < gap; g++) tick;
    end
    chk("read_resp_lat", LINE_W'(dfp_resp), LINE_W'(1));
    tick;
    dfp_read = 1'b0;
    chk("read_resp_one_cycle", LINE_W'(dfp_resp), '0);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] line);
    logic [ADDR_W-1:0] al;
    int n;
    al = {addr[ADDR_W-1:5], 5'b0};
    for (int i = 0; i < 4; i++) wr_q.push_back({al, line[BEAT_W*i +: BEAT_W]});
    resp_q.push_back(line_model);
    dfp_addr   = addr;
    dfp_wdata  = line;
    dfp_write  = 1'b1;
    bmem_ready = 1'b1;
    n = 0;
    do begin tick; n++; end while (!bmem_write && n < 20);
    chk("write_issue_lat", LINE_W'(n), LINE_W'(1));
    // The line was latched and ready is ignored once the burst runs.
    bmem_ready = 1'b0;
    dfp_wdata  = ~line;
    for (int i = 1; i < 4; i++) begin
      tick;
      chk("write_beat_run", LINE_W'(bmem_write), LINE_W'(1));
    end
    tick;
    chk("write_resp_lat", LINE_W'(dfp_resp), LINE_W'(1));
    chk("write_done", LINE_W'(bmem_write), '0);
    tick;
    dfp_write  = 1'b0;
    bmem_ready = 1'b1;
    chk("write_resp_one_cycle", LINE_W'(dfp_resp), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [ADDR_W-1:0] al;
    int n;
    rst = 1'b1;
    dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    repeat (3) tick;
    chk("rst_resp", LINE_W'(dfp_resp), '0);
    chk("rst_read", LINE_W'(bmem_read), '0);
    chk("rst_write", LINE_W'(bmem_write), '0);
    chk("rst_addr", LINE_W'(bmem_addr), '0);
    chk("rst_wdata", LINE_W'(bmem_wdata), '0);
    chk("rst_rdata", dfp_rdata, '0);
    rst = 1'b0;
    tick;

    // Basic read and write.
    do_read(32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 0);
    do_write(32'h0000_0040, {64'hD, 64'hC, 64'hB, 64'hA});
    chk("rdata_kept_by_write", dfp_rdata, line_model);

    // Backpressure, then gapped beats.
    repeat (2) tick;
    do_read(32'h0000_2008, rand_line(), 0, 5);
    do_read(32'h0000_301F, rand_line(), 2, 0);

    // Reset in the middle of a read.
    al = 32'h0000_0500;
    rd_q.push_back(al);
    dfp_addr = al; dfp_read = 1'b1; bmem_ready = 1'b1;
    n = 0;
    do begin tick; n++; end while (!bmem_read && n < 20);
    chk("abort_issue_lat", LINE_W'(n), LINE_W'(1));
    bmem_raddr = al; bmem_rdata = 64'hAAAA_AAAA_AAAA_AAAA; bmem_rvalid = 1'b1;
    tick;
    bmem_rdata = 64'hBBBB_BBBB_BBBB_BBBB;
    tick;
    bmem_rvalid = 1'b0; rst = 1'b1; dfp_read = 1'b0;
    tick;
    rst = 1'b0;
    line_model = '0;
    chk("abort_no_resp", LINE_W'(dfp_resp), '0);
    chk("abort_rdata_cleared", dfp_rdata, '0);
    bmem_rdata = 64'hCCCC_CCCC_CCCC_CCCC; bmem_rvalid = 1'b1;
    tick;
    bmem_rdata = 64'hDDDD_DDDD_DDDD_DDDD;
    tick;
    bmem_rvalid = 1'b0;
    repeat (3) tick;
    chk("idle_beats_ignored", dfp_rdata, '0);
    chk("idle_no_resp", LINE_W'(dfp_resp), '0);
    do_read(32'h0000_0080, rand_line(), 1, 0);

    // Back-to-back read then write.
    do_read(32'h0000_0100, rand_line(), 0, 0);
    do_write(32'h0000_01C0, rand_line());
    chk("b2b_rdata_kept", dfp_rdata, line_model);

    repeat (4) tick;
    chk("read_q_drained", LINE_W'(rd_q.size()), '0);
    chk("write_q_drained", LINE_W'(wr_q.size()), '0);
    chk("resp_q_drained", LINE_W'(resp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
